// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with debounced duty buttons and phase staggering
module pwm_multi #(
    parameter int CHANNELS        = 2,
    parameter int PERIOD          = 10,
    parameter int DUTY_W          = 4,
    parameter int INIT_DUTY       = 5,
    parameter int DEBOUNCE_CYCLES = 4,
    localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_increase_duty,
    input  logic                i_decrease_duty,
    input  logic [CH_W-1:0]     i_ch_sel,
    input  logic                i_mode,
    output logic [CHANNELS-1:0] o_pwm,
    output logic [DUTY_W-1:0]   o_duty,
    output logic                o_period_start
);

    localparam int CNT_W  = $clog2(PERIOD);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int OFFSET = PERIOD / CHANNELS;

    logic [1:0]          inc_sync_q, dec_sync_q;
    logic                inc_lvl_q, dec_lvl_q;
    logic                inc_pulse_q, dec_pulse_q;
    logic [DEB_W-1:0]    deb_cnt_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DUTY_W-1:0]   shadow_q [CHANNELS];
    logic [DUTY_W-1:0]   shadow_d [CHANNELS];
    logic [DUTY_W-1:0]   duty_q   [CHANNELS];
    logic                mode_q;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                start_q;
    logic                tick, wrap;
    int                  phase;

    assign tick           = (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign wrap           = (cnt_q == CNT_W'(PERIOD - 1));
    assign o_pwm          = pwm_q;
    assign o_period_start = start_q;

    // Simultaneous up/down pulses cancel; an unmatched channel select changes nothing.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(i_ch_sel) == k && inc_pulse_q != dec_pulse_q) begin
                if (inc_pulse_q && shadow_q[k] != DUTY_W'(PERIOD))
                    shadow_d[k] = shadow_q[k] + 1'b1;
                else if (dec_pulse_q && shadow_q[k] != '0)
                    shadow_d[k] = shadow_q[k] - 1'b1;
            end
        end
    end

    always_comb begin
        o_duty = '0;
        for (int k = 0; k < CHANNELS; k++)
            if (int'(i_ch_sel) == k) o_duty = shadow_q[k];
    end

    always_comb begin
        pwm_d = '0;
        phase = 0;
        for (int k = 0; k < CHANNELS; k++) begin
            phase = int'(cnt_q) + (mode_q ? k * OFFSET : 0);
            if (phase >= PERIOD) phase = phase - PERIOD;
            pwm_d[k] = (phase < int'(duty_q[k]));
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inc_sync_q  <= '0;
            dec_sync_q  <= '0;
            inc_lvl_q   <= 1'b0;
            dec_lvl_q   <= 1'b0;
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
            deb_cnt_q   <= '0;
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            pwm_q       <= '0;
            start_q     <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                shadow_q[k] <= DUTY_W'(INIT_DUTY);
                duty_q[k]   <= DUTY_W'(INIT_DUTY);
            end
        end else begin
            inc_sync_q  <= {inc_sync_q[0], i_increase_duty};
            dec_sync_q  <= {dec_sync_q[0], i_decrease_duty};
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
            if (tick) begin
                deb_cnt_q   <= '0;
                inc_lvl_q   <= inc_sync_q[1];
                dec_lvl_q   <= dec_sync_q[1];
                inc_pulse_q <= inc_sync_q[1] & ~inc_lvl_q;
                dec_pulse_q <= dec_sync_q[1] & ~dec_lvl_q;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
            shadow_q <= shadow_d;
            // Active settings only change on the wrap so a period is never split.
            if (wrap) begin
                cnt_q  <= '0;
                duty_q <= shadow_q;
                mode_q <= i_mode;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            pwm_q   <= pwm_d;
            start_q <= (cnt_q == '0);
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - randomized self-checking bench for pwm_multi
module tb_pwm_multi;

    localparam int CH   = 2;
    localparam int PER  = 10;
    localparam int DW   = 4;
    localparam int INIT = 5;
    localparam int DEB  = 4;
    localparam int OFF  = PER / CH;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          inc, dec, mode;
    logic [0:0]    ch_sel;
    logic [CH-1:0] pwm;
    logic [DW-1:0] duty;
    logic          ps;

    int          checks = 0;
    int          errors = 0;
    int unsigned ncyc;
    int          mdl_duty [CH];
    bit          mdl_mode;

    pwm_multi dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_increase_duty (inc),
        .i_decrease_duty (dec),
        .i_ch_sel        (ch_sel),
        .i_mode          (mode),
        .o_pwm           (pwm),
        .o_duty          (duty),
        .o_period_start  (ps)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) ncyc <= 0;
        else        ncyc <= ncyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] exp_pattern(input int k, input int d, input bit md);
        logic [31:0] p;
        p = '0;
        for (int pos = 0; pos < PER; pos++)
            p[pos] = (((pos + (md ? k * OFF : 0)) % PER) < d);
        return p;
    endfunction

    task automatic press(input bit up, input bit down, input int hold);
        int c;
        c = int'(ch_sel);
        @(negedge clk);
        inc = up;
        dec = down;
        idle(hold);
        inc = 1'b0;
        dec = 1'b0;
        idle(14);
        if (up && !down)      mdl_duty[c] = (mdl_duty[c] < PER) ? mdl_duty[c] + 1 : PER;
        else if (down && !up) mdl_duty[c] = (mdl_duty[c] > 0) ? mdl_duty[c] - 1 : 0;
    endtask

    // Two-cycle pulse placed so no sample tick can see it.
    task automatic glitch(input bit up);
        int guard;
        guard = 0;
        @(negedge clk);
        while (ncyc % DEB != 3 && guard < 2 * DEB) begin
            @(negedge clk);
            guard++;
        end
        if (up) inc = 1'b1; else dec = 1'b1;
        idle(2);
        inc = 1'b0;
        dec = 1'b0;
        idle(14);
    endtask

    task automatic check_duties(input string tag);
        logic [0:0] save;
        save = ch_sel;
        for (int k = 0; k < CH; k++) begin
            ch_sel = k[0:0];
            #1;
            check($sformatf("%s o_duty ch%0d", tag, k), 32'(duty), 32'(mdl_duty[k]));
        end
        ch_sel = save;
    endtask

    // Observes one full period from a period start; optionally flips i_mode mid-period.
    task automatic check_period(input string tag, input int switch_pos);
        int          waited, extra;
        logic [31:0] obs [CH];
        logic [31:0] exp [CH];
        waited = 0;
        extra  = 0;
        while (!ps && waited < 2 * PER + 2) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " start"}, 32'(ps), 32'd1);
        for (int k = 0; k < CH; k++) begin
            obs[k] = '0;
            exp[k] = exp_pattern(k, mdl_duty[k], mdl_mode);
        end
        for (int pos = 0; pos < PER; pos++) begin
            if (pos > 0) @(negedge clk);
            for (int k = 0; k < CH; k++) obs[k][pos] = pwm[k];
            if (pos > 0 && ps) extra++;
            if (pos == switch_pos) mode = ~mode;
        end
        if (switch_pos >= 0) mdl_mode = mode;
        for (int k = 0; k < CH; k++)
            check($sformatf("%s pattern ch%0d", tag, k), obs[k], exp[k]);
        check({tag, " extra starts"}, 32'(extra), 32'd0);
        @(negedge clk);
        check({tag, " next start"}, 32'(ps), 32'd1);
    endtask

    task automatic reset_model();
        for (int k = 0; k < CH; k++) mdl_duty[k] = INIT;
        mdl_mode = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int r, h, guard;
        rst_n  = 1'b0;
        inc    = 1'b0;
        dec    = 1'b0;
        mode   = 1'b0;
        ch_sel = '0;
        reset_model();
        idle(3);
        check("reset o_pwm", 32'(pwm), 32'd0);
        check("reset o_period_start", 32'(ps), 32'd0);
        check_duties("reset");

        rst_n = 1'b1;
        @(negedge clk);
        check("first period start", 32'(ps), 32'd1);
        check_period("defaults", -1);

        ch_sel = 1'b1;
        press(1'b1, 1'b0, 40);
        check_duties("held increase");
        check_period("held increase", -1);

        ch_sel = 1'b0;
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 8);
        check_duties("saturate high");
        check_period("saturate high", -1);
        for (int i = 0; i < 11; i++) press(1'b0, 1'b1, 8);
        check_duties("saturate low");
        check_period("saturate low", -1);

        for (int i = 0; i < 5; i++) press(1'b1, 1'b0, 8);
        ch_sel = 1'b1;
        press(1'b0, 1'b1, 10);
        mode     = 1'b1;
        mdl_mode = 1'b1;
        idle(PER + 2);
        check_period("staggered", -1);
        check_period("mid switch", 3);
        check_period("after switch", -1);

        press(1'b1, 1'b1, 12);
        check_duties("both buttons");
        glitch(1'b1);
        glitch(1'b0);
        check_duties("glitch");

        for (int it = 0; it < 25; it++) begin
            r = $urandom_range(0, 5);
            h = $urandom_range(8, 30);
            ch_sel = 1'($urandom_range(0, 1));
            case (r)
                0, 1: press(1'b1, 1'b0, h);
                2:    press(1'b0, 1'b1, h);
                3:    press(1'b1, 1'b1, h);
                4:    glitch(1'($urandom_range(0, 1)));
                default: begin
                    @(negedge clk);
                    mode     = ~mode;
                    mdl_mode = mode;
                    idle(PER + 2);
                end
            endcase
            check_duties($sformatf("rand%0d", it));
            check_period($sformatf("rand%0d", it), -1);
        end

        ch_sel = 1'b0;
        mode   = 1'b0;
        mdl_mode = 1'b0;
        guard  = 0;
        while (mdl_duty[0] != 8 && guard < 12) begin
            press(mdl_duty[0] < 8, mdl_duty[0] > 8, 8);
            guard++;
        end
        idle(PER + 2);
        guard = 0;
        while (!ps && guard < 2 * PER + 2) begin
            @(negedge clk);
            guard++;
        end
        idle(2);
        check("pre-reset pwm0 high", 32'(pwm[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        reset_model();
        check("async reset o_pwm", 32'(pwm), 32'd0);
        check("async reset o_period_start", 32'(ps), 32'd0);
        check_duties("async reset");
        idle(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("post reset first start", 32'(ps), 32'd1);
        check_period("post reset", -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
